// File: rtl/counter_defs_pkg.sv
// Shared definitions for the debounced up/down counter: event encoding,
// board-rate timing defaults and counting-mode constants.
package counter_defs_pkg;

  // Default timing for the 50 MHz board clock.
  localparam int unsigned DEBOUNCE_CYCLES_50MHZ = 500000;   // 10 ms
  localparam int unsigned HOLD_CYCLES_50MHZ     = 25000000; // 500 ms
  localparam int unsigned REPEAT_CYCLES_50MHZ   = 5000000;  // 100 ms

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_UP   = 2'd1,
    EV_DOWN = 2'd2,
    EV_LOAD = 2'd3
  } cnt_event_e;

  typedef struct packed {
    logic load;
    logic down;
    logic up;
  } btn_vec_t;

  // Load beats everything; simultaneous up and down cancel out.
  function automatic cnt_event_e resolve_event(input btn_vec_t ev);
    cnt_event_e res;
    res = EV_NONE;
    if (ev.load) begin
      res = EV_LOAD;
    end else if (ev.up && !ev.down) begin
      res = EV_UP;
    end else if (ev.down && !ev.up) begin
      res = EV_DOWN;
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce_core.sv
// One pushbutton: 2-flop synchroniser, polarity normalisation, stability
// counter and a registered one-cycle press pulse.
module btn_debounce_core
  import counter_defs_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic                IDLE_LVL = BTN_ACTIVE_LOW;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] stable_cnt_q;
  logic             state_q;
  logic             press_q;
  logic             level_c;
  logic             differ_c;
  logic             accept_c;

  assign level_c  = sync_q[1] ^ BTN_ACTIVE_LOW;
  assign differ_c = (level_c != state_q);
  assign accept_c = differ_c && (stable_cnt_q == CNT_LAST);

  // Synchroniser resets to the idle level so reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q       <= {2{IDLE_LVL}};
      stable_cnt_q <= '0;
      state_q      <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      press_q <= accept_c && !state_q;
      if (!differ_c) begin
        stable_cnt_q <= '0;
      end else if (accept_c) begin
        stable_cnt_q <= '0;
        state_q      <= ~state_q;
      end else begin
        stable_cnt_q <= stable_cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = state_q;
  assign press_o = press_q;

endmodule

// File: rtl/debounced_updown_counter.sv
// Debounced up/down/load counter with wrap or saturate mode and limit strobe.
// Optional autorepeat on held up/down buttons: COUNTER_AUTOREPEAT_EN.
module debounced_updown_counter
  import counter_defs_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned SATURATE        = MODE_WRAP,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_50MHZ,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_50MHZ
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             btn_up_i,
  input  logic             btn_down_i,
  input  logic             btn_load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             limit_o,
  output logic [2:0]       btn_state_o
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam bit               SAT_MODE = (SATURATE == MODE_SAT);

  if (WIDTH < 2) begin : g_bad_width
    $error("debounced_updown_counter: WIDTH must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("debounced_updown_counter: DEBOUNCE_CYCLES must be at least 2");
  end
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("debounced_updown_counter: HOLD_CYCLES and REPEAT_CYCLES must be non-zero");
  end

  logic             up_held, down_held, load_held;
  logic             up_press, down_press, load_press;
  btn_vec_t         held_c;
  btn_vec_t         press_c;
  btn_vec_t         rpt_c;
  btn_vec_t         event_vec_c;
  cnt_event_e       event_c;
  logic [WIDTH-1:0] count_c;
  logic             limit_c;

  btn_debounce_core #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_db_up (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_up_i),
    .level_o (up_held),
    .press_o (up_press)
  );

  btn_debounce_core #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_db_down (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_down_i),
    .level_o (down_held),
    .press_o (down_press)
  );

  btn_debounce_core #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_db_load (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_load_i),
    .level_o (load_held),
    .press_o (load_press)
  );

  assign held_c  = {load_held, down_held, up_held};
  assign press_c = {load_press, down_press, up_press};

`ifdef COUNTER_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q;
  logic             rpt_armed_q;
  logic             rpt_run_c;
  logic             rpt_fire_c;

  // Timer sits at zero in the press cycle, so the first repeat lands
  // HOLD_CYCLES after the press event and later ones every REPEAT_CYCLES.
  assign rpt_run_c  = (held_c.up ^ held_c.down) && !held_c.load;
  assign rpt_fire_c = rpt_run_c &&
                      (rpt_cnt_q == (rpt_armed_q ? RPT_W'(REPEAT_CYCLES) : RPT_W'(HOLD_CYCLES)));

  always_ff @(posedge clk_i) begin
    if (rst_i || !rpt_run_c) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else if (rpt_fire_c) begin
      rpt_cnt_q   <= RPT_W'(1);
      rpt_armed_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_q + RPT_W'(1);
    end
  end

  assign rpt_c = {1'b0, held_c.down & rpt_fire_c, held_c.up & rpt_fire_c};
`else
  assign rpt_c = '0;
`endif

  assign event_vec_c = press_c | rpt_c;
  assign event_c     = resolve_event(event_vec_c);

  // Next count and limit strobe for the winning event.
  always_comb begin
    count_c = count_o;
    limit_c = 1'b0;
    unique case (event_c)
      EV_LOAD: count_c = load_val_i;
      EV_UP: begin
        if (count_o == CNT_MAX) begin
          limit_c = 1'b1;
          count_c = SAT_MODE ? CNT_MAX : '0;
        end else begin
          count_c = count_o + WIDTH'(1);
        end
      end
      EV_DOWN: begin
        if (count_o == '0) begin
          limit_c = 1'b1;
          count_c = SAT_MODE ? '0 : CNT_MAX;
        end else begin
          count_c = count_o - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o     <= '0;
      limit_o     <= 1'b0;
      btn_state_o <= '0;
    end else begin
      count_o     <= count_c;
      limit_o     <= limit_c;
      btn_state_o <= held_c;
    end
  end

endmodule
